// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester and the APB slave models that talk to it.
package apb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Encoding 2'b11 is never entered; the requester treats it as IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait states and flags the edge on which the wait budget runs out.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Fires on the wait that would bring the count to TIMEOUT, so the abort
    // lands on the TIMEOUT-th ACCESS edge rather than one cycle later.
    assign o_expired = (TIMEOUT != 0) && i_en && (r_count == LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester: one command in, one IDLE/SETUP/ACCESS transfer out, one response pulse back.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              P_clk,
    input  logic              P_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] P_addr,
    output logic              P_write,
    output logic [DATA_W-1:0] P_wdata,
    output logic              P_selx,
    output logic              P_enable,
    input  logic              P_ready,
    input  logic              P_slverr,
    input  logic [DATA_W-1:0] P_rdata
);

    apb_state_e        r_state;
    logic              r_cmd_ready;
    logic              r_selx;
    logic              r_enable;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_rsp_timeout;

    logic w_timer_clr;
    logic w_timer_en;
    logic w_expired;

    assign w_timer_clr = (r_state == SETUP);
    assign w_timer_en  = (r_state == ACCESS) && !P_ready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .i_clk     (P_clk),
        .i_rst     (P_rst),
        .i_clr     (w_timer_clr),
        .i_en      (w_timer_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge P_clk or posedge P_rst) begin
        if (P_rst) begin
            r_state       <= IDLE;
            r_cmd_ready   <= 1'b1;
            r_selx        <= 1'b0;
            r_enable      <= 1'b0;
            r_write       <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                SETUP: begin
                    r_state  <= ACCESS;
                    r_enable <= 1'b1;
                end
                ACCESS: begin
                    if (P_ready) begin
                        r_state       <= IDLE;
                        r_cmd_ready   <= 1'b1;
                        r_selx        <= 1'b0;
                        r_enable      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= r_write ? '0 : P_rdata;
                        r_rsp_err     <= P_slverr;
                        r_rsp_timeout <= 1'b0;
                    end else if (w_expired) begin
                        r_state       <= IDLE;
                        r_cmd_ready   <= 1'b1;
                        r_selx        <= 1'b0;
                        r_enable      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                    end
                end
                default: begin
                    // IDLE, and the unused encoding falls back here too.
                    r_selx   <= 1'b0;
                    r_enable <= 1'b0;
                    if (cmd_valid && r_cmd_ready) begin
                        r_state     <= SETUP;
                        r_cmd_ready <= 1'b0;
                        r_selx      <= 1'b1;
                        r_write     <= cmd_write;
                        r_addr      <= cmd_addr;
                        r_wdata     <= cmd_wdata;
                    end else begin
                        r_state     <= IDLE;
                        r_cmd_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign P_selx      = r_selx;
    assign P_enable    = r_enable;
    assign P_write     = r_write;
    assign P_addr      = r_addr;
    assign P_wdata     = r_wdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;

endmodule
